sobel_window_gen: RTL and testbench

Raster-to-window front end for the edge-detection path. It accepts a pixel stream one 8-bit pixel at a time in row-major order and keeps the two previous image rows in internal line buffers. For each interior pixel it emits a complete 3x3 neighbourhood on nine parallel 8-bit outputs, which feed the Sobel kernel's `data_i_0..data_i_8` window inputs. A valid/ready handshake on both sides lets a slow, multi-cycle kernel stall the stream without dropping pixels.

---
 rtl/sobel_window_gen.sv | 82 ++++++++
 tb/tb_sobel_window_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster pixel stream to 3x3 neighbourhood windows for the Sobel kernel
// Ports: clk, rst (async, active-high);
//   pix_valid_i/pix_i/pix_ready_o: pixel input handshake, row-major order;
//   win_valid_o/win_ready_i: window output handshake;
//   data_o_0..data_o_8: window pixels row-major, top row (r-2) first, left column (c-2) first;
//   frame_done_o: one-cycle pulse after the last pixel of a frame is accepted.
module sobel_window_gen #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_valid_i,
  input  logic [7:0] pix_i,
  output logic       pix_ready_o,
  output logic       win_valid_o,
  input  logic       win_ready_i,
  output logic [7:0] data_o_0,
  output logic [7:0] data_o_1,
  output logic [7:0] data_o_2,
  output logic [7:0] data_o_3,
  output logic [7:0] data_o_4,
  output logic [7:0] data_o_5,
  output logic [7:0] data_o_6,
  output logic [7:0] data_o_7,
  output logic [7:0] data_o_8,
  output logic       frame_done_o
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0] lb0 [IMG_W];
  logic [7:0] lb1 [IMG_W];
  logic [7:0] win [9];
  logic pix_acc, last_col, last_row, produce;
  assign pix_ready_o = !win_valid_o | win_ready_i;
  assign pix_acc = pix_valid_i & pix_ready_o;
  assign last_col = col == CW'(IMG_W - 1);
  assign last_row = row == RW'(IMG_H - 1);
  // columns 0 and 1 still carry the previous row's tail, so only c >= 2 completes a window
  assign produce = pix_acc && row >= RW'(2) && col >= CW'(2);
  // line buffers need no reset: rows 0 and 1 of every frame overwrite them before use
  always_ff @(posedge clk)
    if (pix_acc) begin
      lb1[col] <= lb0[col];
      lb0[col] <= pix_i;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col <= '0;
      row <= '0;
      win_valid_o <= 1'b0;
      frame_done_o <= 1'b0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      frame_done_o <= pix_acc & last_col & last_row;
      win_valid_o <= produce | (win_valid_o & ~win_ready_i);
      if (pix_acc) begin
        col <= last_col ? '0 : col + CW'(1);
        row <= !last_col ? row : last_row ? '0 : row + RW'(1);
        win[0] <= win[1];
        win[1] <= win[2];
        win[2] <= lb1[col];
        win[3] <= win[4];
        win[4] <= win[5];
        win[5] <= lb0[col];
        win[6] <= win[7];
        win[7] <= win[8];
        win[8] <= pix_i;
      end
    end
  assign data_o_0 = win[0];
  assign data_o_1 = win[1];
  assign data_o_2 = win[2];
  assign data_o_3 = win[3];
  assign data_o_4 = win[4];
  assign data_o_5 = win[5];
  assign data_o_6 = win[6];
  assign data_o_7 = win[7];
  assign data_o_8 = win[8];
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: scoreboard bench for sobel_window_gen at 4x4, 16x8 and 3x3 sizes
module tb_sobel_window_gen;
  typedef struct {
    int inst;
    logic [71:0] win;
  } exp_t;
  logic clk, rst;
  logic [2:0] pv, pr, wv, wr, fd;
  logic [7:0] px [3];
  logic [7:0] d [3][9];
  logic [7:0] img [256];
  exp_t sb[$];
  logic [71:0] got[$];
  logic [71:0] t1[$];
  int fd_cnt [3];
  int nerr = 0, nchk = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sobel_window_gen #(
      .IMG_W(g == 0 ? 4 : g == 1 ? 16 : 3),
      .IMG_H(g == 0 ? 4 : g == 1 ? 8 : 3)
    ) dut (
      .clk(clk), .rst(rst),
      .pix_valid_i(pv[g]), .pix_i(px[g]), .pix_ready_o(pr[g]),
      .win_valid_o(wv[g]), .win_ready_i(wr[g]),
      .data_o_0(d[g][0]), .data_o_1(d[g][1]), .data_o_2(d[g][2]),
      .data_o_3(d[g][3]), .data_o_4(d[g][4]), .data_o_5(d[g][5]),
      .data_o_6(d[g][6]), .data_o_7(d[g][7]), .data_o_8(d[g][8]),
      .frame_done_o(fd[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [71:0] a, logic [71:0] b);
    nchk++;
    if (a !== b) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, a, b);
    end
  endtask

  function automatic logic [71:0] pk(int i);
    logic [71:0] r = '0;
    for (int k = 0; k < 9; k++) r = {r[63:0], d[i][k]};
    return r;
  endfunction

  // reference: fill an image and queue every interior 3x3 neighbourhood in raster order
  task automatic load_frame(int inst, int w, int h, int base, int mode);
    exp_t e;
    for (int i = 0; i < w * h; i++)
      img[base + i] = mode == 0 ? 8'(16 * (i / w) + i % w) : mode == 1 ? 8'($urandom) : 8'(i + 1);
    for (int r = 2; r < h; r++)
      for (int c = 2; c < w; c++) begin
        e.inst = inst;
        e.win = '0;
        for (int k = 0; k < 9; k++) e.win = {e.win[63:0], img[base + (r - 2 + k / 3) * w + c - 2 + k % 3]};
        sb.push_back(e);
      end
  endtask

  task automatic run_frame(int inst, int base, int n, int vprob, int rprob, bit stall, bit last);
    int idx = 0, cyc = 0, st = -1;
    logic [71:0] snap = '0;
    while (idx < n && cyc < 5000) begin
      if (stall && st < 0 && wv[inst]) begin
        st = 5;
        snap = pk(inst);
      end
      pv[inst] = int'($urandom_range(99)) < vprob;
      px[inst] = img[base + idx];
      wr[inst] = st > 0 ? 1'b0 : int'($urandom_range(99)) < rprob;
      @(negedge clk);
      if (st > 0) begin
        chk("stall_ready", pr[inst], 0);
        chk("stall_data", pk(inst), snap);
        st--;
      end
      if (pv[inst] && pr[inst]) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    pv[inst] = 1'b0;
    chk("frame_pixels", idx, n);
    if (last) chk("frame_done", fd[inst], 1);
  endtask

  task automatic drain(int inst);
    int cyc = 0;
    pv[inst] = 1'b0;
    wr[inst] = 1'b1;
    while ((sb.size() > 0 || wv[inst]) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_idle", wv[inst], 0);
  endtask

  always @(negedge clk)
    if (!rst)
      for (int i = 0; i < 3; i++) begin
        if (fd[i]) fd_cnt[i]++;
        if (wv[i] && wr[i]) begin
          logic [71:0] w;
          exp_t e;
          w = pk(i);
          got.push_back(w);
          if (sb.size() == 0) chk("unexpected_window", w, 0);
          else begin
            e = sb.pop_front();
            chk("sb_inst", i, e.inst);
            chk("sb_win", w, e.win);
          end
        end
      end

  initial begin
    rst = 1'b1;
    pv = '0;
    wr = '0;
    for (int i = 0; i < 3; i++) px[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_valid", wv[i], 0);
      chk("rst_done", fd[i], 0);
      chk("rst_data", pk(i), 0);
      chk("rst_ready", pr[i], 1);
    end
    rst = 1'b0;
    // 4x4 ramp, free-flowing downstream
    got.delete();
    fd_cnt = '{0, 0, 0};
    load_frame(0, 4, 4, 0, 0);
    run_frame(0, 0, 16, 100, 100, 0, 1);
    @(posedge clk);
    #1;
    chk("frame_done_single", fd[0], 0);
    drain(0);
    chk("t1_count", got.size(), 4);
    chk("t1_first", got[0], 72'h00_01_02_10_11_12_20_21_22);
    chk("t1_last_d8", got[3][7:0], 8'h33);
    chk("t1_last_d0", got[3][71:64], 8'h11);
    chk("t1_fd", fd_cnt[0], 1);
    t1 = got;
    // same stream with a 5-cycle stall after the first window
    got.delete();
    load_frame(0, 4, 4, 0, 0);
    run_frame(0, 0, 16, 100, 100, 1, 1);
    drain(0);
    chk("t2_count", got.size(), t1.size());
    for (int k = 0; k < 4; k++) chk("t2_win", got[k], t1[k]);
    // two frames back to back
    got.delete();
    fd_cnt[0] = 0;
    load_frame(0, 4, 4, 0, 1);
    load_frame(0, 4, 4, 16, 1);
    run_frame(0, 0, 16, 100, 100, 0, 1);
    run_frame(0, 16, 16, 100, 100, 0, 1);
    drain(0);
    chk("t4_count", got.size(), 8);
    chk("t4_fd", fd_cnt[0], 2);
    // asynchronous reset with a window pending and input stalled
    got.delete();
    load_frame(0, 4, 4, 0, 0);
    run_frame(0, 0, 11, 100, 0, 0, 0);
    chk("t5_pending", wv[0], 1);
    chk("t5_stalled", pr[0], 0);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", wv[0], 0);
    chk("t5_async_data", pk(0), 0);
    chk("t5_async_ready", pr[0], 1);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    load_frame(0, 4, 4, 0, 1);
    run_frame(0, 0, 16, 100, 100, 0, 1);
    drain(0);
    chk("t5_count", got.size(), 4);
    // 16x8 with random input gaps and random downstream ready
    got.delete();
    fd_cnt[1] = 0;
    load_frame(1, 16, 8, 0, 1);
    run_frame(1, 0, 128, 70, 60, 0, 1);
    drain(1);
    chk("t3_count", got.size(), 84);
    chk("t3_fd", fd_cnt[1], 1);
    // minimum 3x3 frame
    got.delete();
    load_frame(2, 3, 3, 0, 2);
    run_frame(2, 0, 9, 100, 100, 0, 1);
    drain(2);
    chk("t6_count", got.size(), 1);
    chk("t6_win", got[0], 72'h01_02_03_04_05_06_07_08_09);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
